pipe_bus_skid_rx: RTL and testbench

//  Receiving end of the packed pipeline bus produced by the stage flops.
//  2-entry skid buffer, valid/ready handshake, between a producer stage and a

---
 rtl/pipe_bus_skid_rx.sv | 144 ++++++++++++++
 tb/tb_pipe_bus_skid_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_bus_skid_rx.sv
// pipe_bus_skid_rx
//   Receiving end of the packed pipeline bus. This is a 2-entry skid buffer
//   (HEAD + SKID) with a valid/ready handshake, placed between a producer
//   stage and a consumer that can stall.
//   The head entry is presented both as the packed bus and as decoded key
//   fields. i_ready comes straight from a flop, so the upstream ready path is
//   broken. The block supports a synchronous flush and keeps a saturating
//   count of stall cycles.
//
// Packed bus layout (MSB..LSB):
//   PC_reg[32] | instruct[32] | rd[5] | reg_write_en[1] | rd_data[32]
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   flush             synchronous flush; empties the buffer
//   i_valid/i_ready   upstream handshake (i_ready registered)
//   i_bus             upstream packed bus
//   o_valid/o_ready   downstream handshake for the head entry
//   o_bus             head entry, or a NOP bubble when empty
//   o_PC_reg, o_instruct, o_rd, o_reg_write_en, o_rd_data
//                     decoded fields of o_bus
//   o_count           occupancy 0..2
//   o_stall_cycles    saturating count of o_valid & !o_ready cycles
module pipe_bus_skid_rx #(
    parameter int WIDTH = 102,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_bus,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_bus,
    output logic [31:0]      o_PC_reg,
    output logic [31:0]      o_instruct,
    output logic [4:0]       o_rd,
    output logic             o_reg_write_en,
    output logic [31:0]      o_rd_data,
    output logic [1:0]       o_count,
    output logic [CNT_W-1:0] o_stall_cycles
);

    // Field positions within the packed bus.
    localparam int RD_DATA_LSB = 0;
    localparam int RWE_BIT     = 32;
    localparam int RD_LSB      = 33;
    localparam int INSTR_LSB   = 38;
    localparam int PC_LSB      = 70;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             rdy_q;
    logic [CNT_W-1:0] stall_q;

    logic accept, pop;
    logic [WIDTH-1:0] bubble;

    assign accept = i_valid & rdy_q;
    assign pop    = o_valid & o_ready;

    // NOP bubble: "addi x0, x0, 0" in the instruct field, every other field zero.
    always_comb begin
        bubble = '0;
        bubble[INSTR_LSB +: 32] = 32'h0000_0013;
    end

    // Next-state logic for occupancy and storage.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        skid_d = skid_q;
        case (cnt_q)
            EMPTY: begin
                if (accept) begin
                    cnt_d  = ONE;
                    head_d = i_bus;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    cnt_d  = FULL;
                    skid_d = i_bus;
                end else if (accept && pop) begin
                    head_d = i_bus;
                end else if (pop) begin
                    cnt_d = EMPTY;
                end
            end
            FULL: begin
                // i_ready is low here, so nothing can be accepted.
                if (pop) begin
                    cnt_d  = ONE;
                    head_d = skid_q;
                end
            end
            default: cnt_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= EMPTY;
            rdy_q   <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            // A flush does not clear the stall counter; only reset does.
            if (o_valid && !o_ready && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
            if (flush) begin
                cnt_q <= EMPTY;
                rdy_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_d;
                head_q <= head_d;
                skid_q <= skid_d;
                // Ready is computed from the next occupancy, so it never
                // depends combinationally on o_ready.
                rdy_q  <= (cnt_d != FULL);
            end
        end
    end

    assign i_ready        = rdy_q;
    assign o_valid        = (cnt_q != EMPTY);
    assign o_count        = cnt_q;
    assign o_bus          = o_valid ? head_q : bubble;
    assign o_PC_reg       = o_bus[PC_LSB +: 32];
    assign o_instruct     = o_bus[INSTR_LSB +: 32];
    assign o_rd           = o_bus[RD_LSB +: 5];
    assign o_reg_write_en = o_bus[RWE_BIT] & o_valid;
    assign o_rd_data      = o_bus[RD_DATA_LSB +: 32];
    assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_bus_skid_rx.sv
module tb_pipe_bus_skid_rx;

    localparam int WIDTH = 102;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, flush, i_valid, i_ready, o_valid, o_ready;
    logic [WIDTH-1:0] i_bus, o_bus;
    logic [31:0]      o_PC_reg, o_instruct, o_rd_data;
    logic [4:0]       o_rd;
    logic             o_reg_write_en;
    logic [1:0]       o_count;
    logic [CNT_W-1:0] o_stall_cycles;

    always #5 clk = ~clk;

    pipe_bus_skid_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready), .i_bus(i_bus),
        .o_valid(o_valid), .o_ready(o_ready), .o_bus(o_bus),
        .o_PC_reg(o_PC_reg), .o_instruct(o_instruct), .o_rd(o_rd),
        .o_reg_write_en(o_reg_write_en), .o_rd_data(o_rd_data),
        .o_count(o_count), .o_stall_cycles(o_stall_cycles)
    );

    typedef struct {
        logic        rst_n, flush, iv, ordy;
        logic [31:0] pc;
        logic        ev, er;
        logic [1:0]  ec;
        logic [31:0] epc;
        logic [31:0] est;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt = 0;
    int   total    = 0;

    // Test entry: distinct, non-bubble contents derived from the PC.
    function automatic logic [WIDTH-1:0] mk(input logic [31:0] pc);
        mk = {pc, pc ^ 32'hABCD_0000, pc[6:2], 1'b1, ~pc};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] pc, input logic ev, input logic er,
                       input logic [1:0] ec, input logic [31:0] epc, input logic [31:0] est);
        vec_t v;
        v.rst_n = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.pc = pc;
        v.ev = ev; v.er = er; v.ec = ec; v.epc = epc; v.est = est;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic ordy, input logic [31:0] pc);
        rst_n = r; flush = f; i_valid = iv; o_ready = ordy; i_bus = mk(pc);
        @(posedge clk);
        #1;
    endtask

    // Checks the head entry and its decoded fields against the model entry.
    task automatic check_out(input string tag, input logic ev, input logic [31:0] epc);
        logic [WIDTH-1:0] e;
        e = mk(epc);
        check({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, ev});
        check({tag, ".pc"}, o_PC_reg, ev ? epc : 32'd0);
        check({tag, ".instr"}, o_instruct, ev ? e[69:38] : 32'h0000_0013);
        check({tag, ".rd"}, {27'd0, o_rd}, ev ? {27'd0, e[37:33]} : 32'd0);
        check({tag, ".rwe"}, {31'd0, o_reg_write_en}, {31'd0, ev});
        check({tag, ".rd_data"}, o_rd_data, ev ? ~epc : 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_bus = '0;

        // reset, 2 cycles
        add(0,0,0,0, 0,     0,1,0, 0, 0);
        add(0,0,0,0, 0,     0,1,0, 0, 0);
        // streaming, 8 back-to-back entries
        for (int k = 0; k < 8; k++)
            add(1,0,1,1, 32'h100 + 4*k, 1,1,1, 32'h100 + 4*k, 0);
        add(1,0,0,1, 0,     0,1,0, 0, 0);
        // backpressure: A, B, C held, then drain
        add(1,0,1,0, 32'h200, 1,1,1, 32'h200, 0);
        add(1,0,1,0, 32'h204, 1,0,2, 32'h200, 1);
        add(1,0,1,0, 32'h208, 1,0,2, 32'h200, 2);
        add(1,0,1,0, 32'h208, 1,0,2, 32'h200, 3);
        add(1,0,1,1, 32'h208, 1,1,1, 32'h204, 3);
        add(1,0,1,1, 32'h208, 1,1,1, 32'h208, 3);
        add(1,0,0,1, 0,       0,1,0, 0,       3);
        // flush while FULL with i_valid=1; the input in the flush cycle is lost
        add(1,0,1,0, 32'h300, 1,1,1, 32'h300, 3);
        add(1,0,1,0, 32'h304, 1,0,2, 32'h300, 4);
        add(1,1,1,0, 32'h308, 0,1,0, 0,       5);
        add(1,0,0,1, 0,       0,1,0, 0,       5);

        foreach (vq[n]) begin
            string t;
            t = $sformatf("v%0d", n);
            drive(vq[n].rst_n, vq[n].flush, vq[n].iv, vq[n].ordy, vq[n].pc);
            check_out(t, vq[n].ev, vq[n].epc);
            check({t, ".i_ready"}, {31'd0, i_ready}, {31'd0, vq[n].er});
            check({t, ".count"}, {30'd0, o_count}, {30'd0, vq[n].ec});
            check({t, ".stall"}, {28'd0, o_stall_cycles}, vq[n].est);
        end

        // saturation: one entry held with o_ready=0 for 20 cycles
        drive(1,0,1,0, 32'h400);
        check("sat.load.stall", {28'd0, o_stall_cycles}, 32'd5);
        for (int k = 0; k < 9; k++) drive(1,0,0,0, 0);
        check("sat.mid.stall", {28'd0, o_stall_cycles}, 32'd14);
        for (int k = 0; k < 11; k++) drive(1,0,0,0, 0);
        check("sat.end.stall", {28'd0, o_stall_cycles}, 32'd15);
        check("sat.count", {30'd0, o_count}, 32'd1);
        check_out("sat", 1'b1, 32'h400);

        // reset mid-operation: fill to FULL, then reset with flush and o_ready high
        drive(1,0,1,0, 32'h404);
        check("rm.full.count", {30'd0, o_count}, 32'd2);
        check("rm.full.i_ready", {31'd0, i_ready}, 32'd0);
        drive(0,1,1,1, 32'h408);
        drive(0,1,1,1, 32'h408);
        check_out("rm", 1'b0, 0);
        check("rm.i_ready", {31'd0, i_ready}, 32'd1);
        check("rm.count", {30'd0, o_count}, 32'd0);
        check("rm.stall", {28'd0, o_stall_cycles}, 32'd0);
        drive(1,0,0,1, 0);
        check_out("rm.post", 1'b0, 0);
        check("rm.post.count", {30'd0, o_count}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
